// File: rtl/button_irq_ctrl_if.sv
// Register bus between a CPU-side master and button_irq_ctrl.
//   ADDR   : byte address (bits [1:0] ignored by the slave)
//   WE     : write strobe, one transfer per cycle
//   WDATA  : write data
//   RE     : read strobe
//   RDATA  : read data, valid when RVALID=1, held otherwise
//   RVALID : one-cycle strobe, one cycle after RE
interface button_irq_ctrl_if;
  logic [4:0]  ADDR;
  logic        WE;
  logic [31:0] WDATA;
  logic        RE;
  logic [31:0] RDATA;
  logic        RVALID;

  modport master (output ADDR, WE, WDATA, RE, input  RDATA, RVALID);
  modport slave  (input  ADDR, WE, WDATA, RE, output RDATA, RVALID);
endinterface

// File: rtl/button_irq_ctrl.sv
// Button interrupt controller: five press-pulse inputs (U, L, R, D, C),
// per-button sticky PENDING bits, interrupt ENABLE mask, saturating 8-bit
// press counters, and a small register bus with 1-cycle read latency.
//   CLK     : clock, rising edge
//   RESET   : synchronous active-high reset
//   BTN_INT : one-cycle press pulses, bit0=U bit1=L bit2=R bit3=D bit4=C
//   bus     : register bus (slave side), see button_irq_ctrl_if
//   IRQ     : level interrupt = OR(PENDING & ENABLE)
// Map: 0x00 PENDING (W1C), 0x04 ENABLE, 0x08 ACTIVE (RO), 0x0C COUNT0,
//      0x10 COUNT1, 0x14 CTRL (WO, bit0 clears counters), others read 0.

// Per-button state: sticky pending bit and saturating press counter.
module btn_lane #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             pulse,
  input  logic             pend_clr,
  input  logic             cnt_clr,
  output logic             pend,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend <= 1'b0;
      cnt  <= '0;
    end else begin
      // a press in the same cycle as a W1C keeps the bit set
      pend <= pulse | (pend & ~pend_clr);
      // a press coinciding with a counter clear leaves a count of 1
      if (cnt_clr)                  cnt <= CNT_W'(pulse);
      else if (pulse && cnt != '1)  cnt <= cnt + 1'b1;
    end
  end
endmodule

module button_irq_ctrl (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [4:0]         BTN_INT,
  button_irq_ctrl_if.slave   bus,
  output logic               IRQ
);
  localparam int NUM_LANES = 5;
  localparam int CNT_W     = 8;

  localparam logic [2:0] A_PEND  = 3'd0;
  localparam logic [2:0] A_EN    = 3'd1;
  localparam logic [2:0] A_ACT   = 3'd2;
  localparam logic [2:0] A_CNT0  = 3'd3;
  localparam logic [2:0] A_CNT1  = 3'd4;
  localparam logic [2:0] A_CTRL  = 3'd5;

  logic [NUM_LANES-1:0]            pend, en;
  logic [NUM_LANES-1:0][CNT_W-1:0] cnt;
  logic [2:0]                      sel;
  logic                            wr_pend, wr_en, wr_clr;
  logic [31:0]                     rd_nxt;
  logic                            unused_ok;

  assign sel     = bus.ADDR[4:2];
  assign wr_pend = bus.WE && sel == A_PEND;
  assign wr_en   = bus.WE && sel == A_EN;
  assign wr_clr  = bus.WE && sel == A_CTRL && bus.WDATA[0];

  assign unused_ok = ^{bus.ADDR[1:0], bus.WDATA[31:5]};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    btn_lane #(.CNT_W(CNT_W)) u_lane (
      .CLK      (CLK),
      .RESET    (RESET),
      .pulse    (BTN_INT[g]),
      .pend_clr (wr_pend & bus.WDATA[g]),
      .cnt_clr  (wr_clr),
      .pend     (pend[g]),
      .cnt      (cnt[g])
    );
  end

  always_ff @(posedge CLK) begin
    if (RESET)      en <= '0;
    else if (wr_en) en <= bus.WDATA[NUM_LANES-1:0];
  end

  // read mux works on pre-update state, so a same-cycle write is not visible
  always_comb begin
    rd_nxt = '0;
    case (sel)
      A_PEND: rd_nxt[NUM_LANES-1:0] = pend;
      A_EN:   rd_nxt[NUM_LANES-1:0] = en;
      A_ACT:  rd_nxt[NUM_LANES-1:0] = pend & en;
      A_CNT0: rd_nxt                = cnt[3:0];
      A_CNT1: rd_nxt[CNT_W-1:0]     = cnt[4];
      default: rd_nxt = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bus.RVALID <= 1'b0;
      bus.RDATA  <= '0;
    end else begin
      bus.RVALID <= bus.RE;
      if (bus.RE) bus.RDATA <= rd_nxt;
    end
  end

  assign IRQ = |(pend & en);
endmodule
